// File: rtl/alu_arb_pkg.sv
// Shared constants, state type and select-encoding helper for the ALU result-mux arbiter.
package alu_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // The mux select pins are wired in reverse bit order relative to the index.
  function automatic logic [IDX_W-1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < IDX_W; b++) begin
      res[b] = idx[IDX_W-1-b];
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping mod N_REQ.
module alu_rr_pick
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr_i + IDX_W'(i);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_mux_arbiter.sv
// Round-robin arbiter driving the ALU 16:1 result-mux select with a valid/ready output.
// Optional burst locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_mux_arbiter
  import alu_arb_pkg::*;
`ifdef ALU_ARB_LOCK_EN
#(
  parameter int unsigned BURST_MAX = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef ALU_ARB_LOCK_EN
  input  logic [N_REQ-1:0] lock,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] sel
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

`ifdef ALU_ARB_LOCK_EN
  localparam int unsigned BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  logic [BEAT_W-1:0] beat_q, beat_d;
`endif

  // While granted, the only search that matters is the post-transfer one, which
  // starts just after the current winner -- exactly where ptr will be moved to.
  assign pick_ptr = (state_q == GRANT) ? (gidx_q + IDX_W'(1)) : ptr_q;

  alu_rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
`ifdef ALU_ARB_LOCK_EN
    beat_d  = beat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gidx_d  = pick_idx;
        end
      end
      GRANT: begin
        if (out_ready) begin
`ifdef ALU_ARB_LOCK_EN
          if (lock[gidx_q] && req[gidx_q] && (beat_q < BEAT_LAST)) begin
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            beat_d = '0;
`endif
            ptr_d = gidx_q + IDX_W'(1);
            if (pick_found) begin
              gidx_d = pick_idx;
            end else begin
              state_d = IDLE;
            end
`ifdef ALU_ARB_LOCK_EN
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
`ifdef ALU_ARB_LOCK_EN
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
`ifdef ALU_ARB_LOCK_EN
      beat_q  <= beat_d;
`endif
    end
  end

  assign out_valid = (state_q == GRANT);
  assign gnt       = out_valid ? (N_REQ'(1) << gidx_q) : '0;
  assign gnt_idx   = gidx_q;
  assign sel       = idx_to_sel(gidx_q);

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// Scoreboard bench for alu_mux_arbiter: a round-robin model predicts every cycle's outputs.
module tb_alu_mux_arbiter;

  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] lock = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic [3:0]  sel;

  always #5 clk = ~clk;

`ifdef ALU_ARB_LOCK_EN
  alu_mux_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .out_ready(out_ready),
    .out_valid(out_valid), .gnt(gnt), .gnt_idx(gnt_idx), .sel(sel)
  );
`else
  alu_mux_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .gnt(gnt), .gnt_idx(gnt_idx), .sel(sel)
  );
`endif

  typedef struct {
    bit valid;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: plain integers, mod-16 arithmetic.
  bit m_valid = 0;
  int m_g = 0;
  int m_ptr = 0;
  int m_beat = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  function automatic int rev4(input int v);
    return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
  endfunction

  // Advance the model by one clock edge using the inputs just applied.
  task automatic model_edge();
    int k;
    bit hold;
    if (rst) begin
      m_valid = 0; m_g = 0; m_ptr = 0; m_beat = 0;
    end else if (!m_valid) begin
      k = first_from(req, m_ptr);
      if (k >= 0) begin
        m_valid = 1; m_g = k;
      end
    end else if (out_ready) begin
      hold = 0;
`ifdef ALU_ARB_LOCK_EN
      if (lock[m_g] && req[m_g] && (m_beat + 1 < BM)) hold = 1;
`endif
      if (hold) begin
        m_beat++;
      end else begin
        m_beat = 0;
        m_ptr = (m_g + 1) % 16;
        k = first_from(req, m_ptr);
        if (k >= 0) m_g = k;
        else m_valid = 0;
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input logic rdy, input logic [15:0] lk,
                      input logic rs);
    exp_t e;
    @(negedge clk);
    rst = rs; req = r; out_ready = rdy; lock = lk;
    model_edge();
    e.valid = m_valid;
    e.idx   = m_g;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT outputs after each edge with the queued prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid", int'(out_valid), int'(e.valid));
      chk("gnt", int'(gnt), e.valid ? (1 << e.idx) : 0);
      chk("gnt_idx", int'(gnt_idx), e.idx);
      chk("sel", int'(sel), rev4(e.idx));
    end
  end

  initial begin
    // Reset held with random requests.
    for (int i = 0; i < 4; i++) step(16'($urandom), 1'($urandom), '0, 1'b1);
    step(16'h1230, 1'b0, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Two requesters alternating.
    for (int i = 0; i < 6; i++) step(16'h0101, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Stall with a single requester; request drops at the transfer.
    step(16'h0020, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(16'h0020, 1'b0, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Wrap-around after a grant to 15.
    step(16'h8000, 1'b1, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(16'h8003, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Lock burst starting with ptr=3 (grant 2 first, then move on).
    step(16'h0004, 1'b1, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(16'h0018, 1'b1, 16'h0008, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(16'($urandom & $urandom), ($urandom_range(0, 3) != 0),
           16'($urandom), ($urandom_range(0, 99) == 0));
    end
    step(16'h0, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    // Reset mid-grant must clear outputs before the next edge.
    step(16'h0020, 1'b0, '0, 1'b0);
    step(16'h0020, 1'b0, '0, 1'b0);
    step(16'h0020, 1'b0, '0, 1'b1);
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_sel", int'(sel), 0);
    step(16'h0006, 1'b1, '0, 1'b0);
    step(16'h0006, 1'b1, '0, 1'b0);
    step(16'h0, 1'b1, '0, 1'b0);

    @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
